mem_port_arbiter: RTL and testbench

Arbitrates a single-ported unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage 64-bit RISC-V pipeline. It sequences each access with a req/ready handshake on the memory side, returns read data to the granted requester, and raises per-stage stall signals for the hazard/pipeline-register logic. Data accesses have priority. A starvation counter bounds how long fetch can be locked out.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_arb_starve_cnt.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared pipeline definitions for the unified memory-port arbiter.
// Holds datapath widths, the arbiter state encoding and a counter-width helper.
package mem_port_arbiter_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

  // Bits needed to count 0..max inclusive.
  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of fetch denials; at_max_o tells the arbiter to favour fetch.
// Clear has priority over increment.
module mem_arb_starve_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam int CW = cnt_width(STARVE_MAX);
  localparam logic [CW-1:0] MAX_C = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and load/store, data first,
// with a starvation bound on fetch. All memory-side and response outputs are registered.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [ILEN-1:0] if_rdata,
  output logic            if_valid,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  output logic [XLEN-1:0] dm_rdata,
  output logic            dm_valid,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            stall_if,
  output logic            stall_mem
);

  arb_state_t      state_q;
  logic [ILEN-1:0] if_rdata_q;
  logic [XLEN-1:0] dm_rdata_q;
  logic            if_valid_q;
  logic            dm_valid_q;
  logic            mem_req_q;
  logic            mem_we_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [XLEN-1:0] mem_wdata_q;

  logic if_eff;
  logic dm_eff;
  logic grant_if;
  logic grant_dm;
  logic starve_at_max;

  // A requester is masked in its own completion cycle so it cannot be re-granted
  // on the strength of a request the pipeline is about to retire.
  assign if_eff = if_req && !if_valid_q;
  assign dm_eff = dm_req && !dm_valid_q;

  always_comb begin
    grant_dm = 1'b0;
    grant_if = 1'b0;
    if (state_q == IDLE) begin
      grant_dm = dm_eff && !(if_eff && starve_at_max);
      grant_if = if_eff && !grant_dm;
    end
  end

  mem_arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (grant_dm && if_eff),
    .clr_i   (grant_if),
    .at_max_o(starve_at_max)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_dm) begin
            state_q     <= BUSY_DM;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_we;
            mem_addr_q  <= dm_addr;
            mem_wdata_q <= dm_wdata;
          end else if (grant_if) begin
            state_q     <= BUSY_IF;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
          end
        end
        BUSY_IF: begin
          if (mem_ready) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            if_valid_q <= 1'b1;
            if_rdata_q <= mem_rdata[ILEN-1:0];
          end
        end
        BUSY_DM: begin
          if (mem_ready) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            dm_valid_q <= 1'b1;
            // Stores return nothing; keep the last load value visible.
            if (!mem_we_q) begin
              dm_rdata_q <= mem_rdata;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign stall_if  = if_req && !if_valid_q;
  assign stall_mem = dm_req && !dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: drives and samples on the falling clock edge,
// acting as the memory itself so every expected value is fixed by the stimulus.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic [63:0] dm_rdata;
  logic        dm_valid;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_mem;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_valid (dm_valid),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .stall_if (stall_if),
    .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_if_valid"},  64'(if_valid),  64'h0);
    check({tag, "_dm_valid"},  64'(dm_valid),  64'h0);
    check({tag, "_mem_req"},   64'(mem_req),   64'h0);
    check({tag, "_mem_we"},    64'(mem_we),    64'h0);
    check({tag, "_mem_addr"},  mem_addr,       64'h0);
    check({tag, "_mem_wdata"}, mem_wdata,      64'h0);
    check({tag, "_if_rdata"},  64'(if_rdata),  64'h0);
    check({tag, "_dm_rdata"},  dm_rdata,       64'h0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    @(negedge clk);
    tick();
    check_all_zero("reset");
    check("reset_stall_if", 64'(stall_if), 64'h0);
    check("reset_stall_mem", 64'(stall_mem), 64'h0);
    reset = 1'b0;
    tick();

    // Fetch only, memory answers in the first busy cycle.
    if_req = 1'b1; if_addr = 64'h40;
    #1;
    check("f_stall_t0", 64'(stall_if), 64'h1);
    check("f_mem_req_t0", 64'(mem_req), 64'h0);
    tick();
    check("f_mem_req_t1", 64'(mem_req), 64'h1);
    check("f_mem_addr", mem_addr, 64'h40);
    check("f_mem_we", 64'(mem_we), 64'h0);
    check("f_stall_t1", 64'(stall_if), 64'h1);
    mem_ready = 1'b1; mem_rdata = 64'hFFFF_FFFF_00A3_0023;
    tick();
    check("f_if_valid", 64'(if_valid), 64'h1);
    check("f_if_rdata", 64'(if_rdata), 64'h00A3_0023);
    check("f_mem_req_t2", 64'(mem_req), 64'h0);
    check("f_stall_t2", 64'(stall_if), 64'h0);
    if_req = 1'b0; mem_ready = 1'b0;
    tick();
    check("f_if_valid_t3", 64'(if_valid), 64'h0);

    // Simultaneous requests: data first, fetch granted in the dm_valid cycle.
    if_req = 1'b1; if_addr = 64'h80; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h100;
    tick();
    check("s_dm_first", mem_addr, 64'h100);
    check("s_mem_we", 64'(mem_we), 64'h0);
    check("s_stall_mem", 64'(stall_mem), 64'h1);
    tick(); tick();
    check("s_hold_addr", mem_addr, 64'h100);
    check("s_hold_req", 64'(mem_req), 64'h1);
    mem_ready = 1'b1; mem_rdata = 64'hDEAD;
    tick();
    check("s_dm_valid", 64'(dm_valid), 64'h1);
    check("s_dm_rdata", dm_rdata, 64'hDEAD);
    check("s_stall_mem_fall", 64'(stall_mem), 64'h0);
    check("s_stall_if_held", 64'(stall_if), 64'h1);
    dm_req = 1'b0; mem_ready = 1'b0;
    tick();
    check("s_if_granted", mem_addr, 64'h80);
    check("s_if_req", 64'(mem_req), 64'h1);
    check("s_dm_valid_pulse", 64'(dm_valid), 64'h0);
    mem_ready = 1'b1; mem_rdata = 64'h13;
    tick();
    check("s_if_valid", 64'(if_valid), 64'h1);
    check("s_if_rdata", 64'(if_rdata), 64'h13);
    if_req = 1'b0; mem_ready = 1'b0;
    tick();

    // Starvation: fetch is dropped in each dm_valid cycle so the back-to-back rule
    // does not hand it the port; every data grant then sees fetch effective.
    if_addr = 64'hC0; dm_addr = 64'h180; dm_req = 1'b1; dm_we = 1'b0;
    for (int g = 0; g < 4; g++) begin
      if_req = 1'b1;
      tick();
      check($sformatf("st_dm_grant%0d", g), mem_addr, 64'h180);
      mem_ready = 1'b1; mem_rdata = 64'h500 + 64'(g);
      tick();
      check($sformatf("st_dm_valid%0d", g), 64'(dm_valid), 64'h1);
      mem_ready = 1'b0; if_req = 1'b0;
      tick();
      check($sformatf("st_gap%0d", g), 64'(mem_req), 64'h0);
    end
    if_req = 1'b1;
    tick();
    check("st_if_wins", mem_addr, 64'hC0);
    check("st_if_we", 64'(mem_we), 64'h0);
    mem_ready = 1'b1; mem_rdata = 64'h6F;
    tick();
    check("st_if_valid", 64'(if_valid), 64'h1);
    check("st_if_rdata", 64'(if_rdata), 64'h6F);
    if_req = 1'b0; mem_ready = 1'b0;
    tick();
    check("st_dm_after_if", mem_addr, 64'h180);
    mem_ready = 1'b1; mem_rdata = 64'h777;
    tick();
    check("st_dm_valid_b", 64'(dm_valid), 64'h1);
    mem_ready = 1'b0;
    tick();
    // Counter cleared by the fetch grant: data wins a contested arbitration again.
    if_req = 1'b1;
    tick();
    check("st_cleared_dm_first", mem_addr, 64'h180);
    mem_ready = 1'b1;
    tick();
    check("st_cleared_dm_valid", 64'(dm_valid), 64'h1);
    check("st_cleared_dm_rdata", dm_rdata, 64'h777);
    dm_req = 1'b0; mem_ready = 1'b0;
    tick();
    check("st_cleared_if_next", mem_addr, 64'hC0);
    mem_ready = 1'b1;
    tick();
    check("st_cleared_if_valid", 64'(if_valid), 64'h1);
    if_req = 1'b0; mem_ready = 1'b0;
    tick();

    // Store keeps the previous load data.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h200; dm_wdata = 64'h1234;
    tick();
    check("w_mem_we", 64'(mem_we), 64'h1);
    check("w_mem_wdata", mem_wdata, 64'h1234);
    check("w_mem_addr", mem_addr, 64'h200);
    mem_ready = 1'b1; mem_rdata = 64'hBAD;
    tick();
    check("w_dm_valid", 64'(dm_valid), 64'h1);
    check("w_dm_rdata_kept", dm_rdata, 64'h777);
    dm_req = 1'b0; mem_ready = 1'b0;
    tick();

    // Reset while a load is in flight, coincident with mem_ready.
    dm_we = 1'b0; dm_addr = 64'h300; dm_req = 1'b1;
    tick();
    check("r_busy", 64'(mem_req), 64'h1);
    reset = 1'b1; mem_ready = 1'b1; mem_rdata = 64'hCAFE;
    tick();
    check_all_zero("r_during");
    reset = 1'b0; dm_req = 1'b0;
    tick();
    check_all_zero("r_late_ready");

    // Stray mem_ready while idle.
    tick();
    check("i_no_if_valid", 64'(if_valid), 64'h0);
    check("i_no_dm_valid", 64'(dm_valid), 64'h0);
    check("i_no_req", 64'(mem_req), 64'h0);
    mem_ready = 1'b0; if_req = 1'b1; if_addr = 64'h44;
    tick();
    check("i_if_grant", mem_addr, 64'h44);
    check("i_if_req", 64'(mem_req), 64'h1);
    mem_ready = 1'b1; mem_rdata = 64'h99;
    tick();
    check("i_if_valid", 64'(if_valid), 64'h1);
    check("i_if_rdata", 64'(if_rdata), 64'h99);
    if_req = 1'b0; mem_ready = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
